// File: rtl/lbus_master.sv
// Host-side initiator for the 16-bit local bus: turns single command words into
// timed write/read strobes and supports polling a status field until it clears.
module lbus_master #(
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned STB_CYC   = 3,
    parameter int unsigned HOLD_CYC  = 1,
    parameter logic [23:0] POLL_MAX  = 24'hFFFFFF
) (
    input  logic        clkin,
    input  logic        rstnin,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [15:0] cmd_addr,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_timeout,
    output logic [15:0] lbus_a,
    output logic [15:0] lbus_do,
    input  logic [15:0] lbus_di,
    output logic        lbus_wr,
    output logic        lbus_rd
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        GAP,
        RESP
    } state_t;

    localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STB_LD   = 4'(STB_CYC - 1);
    localparam logic [3:0] HOLD_LD  = (HOLD_CYC == 0) ? 4'd0 : 4'(HOLD_CYC - 1);

    state_t      state;
    logic [3:0]  phase_cnt;
    logic        op_write;
    logic        op_poll;
    logic [15:0] mask;
    logic [15:0] sample;
    logic [23:0] poll_cnt;
    logic [23:0] poll_inc;

    assign poll_inc = (poll_cnt == 24'hFFFFFF) ? poll_cnt : poll_cnt + 24'd1;

    // With HOLD_CYC=0 the strobe falls on the edge that enters RESP, so the
    // address is kept through RESP and only cleared on the way back to IDLE.
    always_ff @(posedge clkin or negedge rstnin) begin
        if (!rstnin) begin
            state       <= IDLE;
            phase_cnt   <= 4'd0;
            op_write    <= 1'b0;
            op_poll     <= 1'b0;
            mask        <= 16'h0000;
            sample      <= 16'h0000;
            poll_cnt    <= 24'd0;
            cmd_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= 16'h0000;
            rsp_timeout <= 1'b0;
            lbus_a      <= 16'h0000;
            lbus_do     <= 16'h0000;
            lbus_wr     <= 1'b0;
            lbus_rd     <= 1'b0;
        end else begin
            rsp_valid   <= 1'b0;
            rsp_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready <= 1'b0;
                        op_write  <= (cmd_op == 2'd0);
                        op_poll   <= (cmd_op == 2'd2);
                        mask      <= cmd_wdata;
                        lbus_a    <= cmd_addr;
                        lbus_do   <= (cmd_op == 2'd0) ? cmd_wdata : 16'h0000;
                        poll_cnt  <= 24'd0;
                        phase_cnt <= SETUP_LD;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    if (phase_cnt == 4'd0) begin
                        lbus_wr   <= op_write;
                        lbus_rd   <= ~op_write;
                        phase_cnt <= STB_LD;
                        state     <= STROBE;
                    end else begin
                        phase_cnt <= phase_cnt - 4'd1;
                    end
                end
                STROBE: begin
                    if (phase_cnt == 4'd0) begin
                        lbus_wr <= 1'b0;
                        lbus_rd <= 1'b0;
                        sample  <= lbus_di;
                        if (HOLD_CYC != 0) begin
                            phase_cnt <= HOLD_LD;
                            state     <= HOLD;
                        end else if (op_poll) begin
                            state <= GAP;
                        end else begin
                            rsp_valid <= 1'b1;
                            rsp_rdata <= op_write ? 16'h0000 : lbus_di;
                            state     <= RESP;
                        end
                    end else begin
                        phase_cnt <= phase_cnt - 4'd1;
                    end
                end
                HOLD: begin
                    if (phase_cnt == 4'd0) begin
                        if (op_poll) begin
                            state <= GAP;
                        end else begin
                            rsp_valid <= 1'b1;
                            rsp_rdata <= op_write ? 16'h0000 : sample;
                            lbus_a    <= 16'h0000;
                            lbus_do   <= 16'h0000;
                            state     <= RESP;
                        end
                    end else begin
                        phase_cnt <= phase_cnt - 4'd1;
                    end
                end
                GAP: begin
                    // A clear field wins over the timeout on the final read.
                    if ((sample & mask) == 16'h0000) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= sample;
                        lbus_a    <= 16'h0000;
                        lbus_do   <= 16'h0000;
                        state     <= RESP;
                    end else begin
                        poll_cnt <= poll_inc;
                        if (poll_inc >= POLL_MAX) begin
                            rsp_valid   <= 1'b1;
                            rsp_timeout <= 1'b1;
                            rsp_rdata   <= sample;
                            lbus_a      <= 16'h0000;
                            lbus_do     <= 16'h0000;
                            state       <= RESP;
                        end else begin
                            phase_cnt <= SETUP_LD;
                            state     <= SETUP;
                        end
                    end
                end
                RESP: begin
                    lbus_a    <= 16'h0000;
                    lbus_do   <= 16'h0000;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    lbus_wr   <= 1'b0;
                    lbus_rd   <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/lbus_master.md
Name: lbus_master

Overview:
- Host-side initiator for the 16-bit local bus that the cipher/RSA target wrappers respond to; lives in the control FPGA between the command decoder and the bus pins.
- Turns single command words into timed write/read strobes on lbus_a/lbus_wr/lbus_rd, and returns read data.
- Supports a poll command: repeated reads of one address until a masked field clears or a timeout expires. Used to wait on target status (e.g. RSA busy / data-valid).

Parameters:
- SETUP_CYC, 2, cycles address/data are stable before the strobe rises (1..15)
- STB_CYC, 3, strobe high width in cycles (1..15)
- HOLD_CYC, 1, cycles address/data are held after the strobe falls (0..15)
- POLL_MAX, 24'hFFFFFF, maximum poll reads before timeout

Ports:
- clkin  in  1  single system clock
- rstnin  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block can accept a command
- cmd_op  in  2  command: 0=write, 1=read, 2=poll, 3=reserved (treated as read)
- cmd_addr  in  16  bus address
- cmd_wdata  in  16  write data (write); poll mask (poll)
- rsp_valid  out  1  one-cycle pulse; response available
- rsp_rdata  out  16  read data; last polled value for poll
- rsp_timeout  out  1  qualifies rsp_valid; poll expired
- lbus_a  out  16  bus address
- lbus_do  out  16  write data toward target (target's lbus_di)
- lbus_di  in  16  read data from target (target's lbus_do)
- lbus_wr  out  1  write strobe, active-high
- lbus_rd  out  1  read strobe, active-high

Behaviour:
- Reset (async, rstnin=0):
  - State IDLE.
  - All outputs 0 except cmd_ready=1.
  - Counters and latches cleared.
- Reset asserted mid-transfer drops any strobe immediately; no response is issued.
- Handshake: a command is accepted when cmd_valid&&cmd_ready. cmd_ready=1 only in IDLE. cmd_op, cmd_addr and cmd_wdata are latched on acceptance.
- State machine: IDLE -> SETUP -> STROBE -> HOLD -> (RESP | GAP) -> IDLE.
  - SETUP:
    - lbus_a=addr.
    - lbus_do=wdata for writes, 0 otherwise.
    - Lasts SETUP_CYC cycles.
  - STROBE:
    - lbus_wr (write) or lbus_rd (read/poll) is 1 for exactly STB_CYC cycles.
    - Address/data unchanged.
    - Read data is sampled from lbus_di on the last STROBE cycle.
  - HOLD:
    - Strobes 0; lbus_a/lbus_do held for HOLD_CYC cycles.
    - HOLD_CYC=0 skips directly to the next state.
  - RESP (1 cycle):
    - rsp_valid=1.
    - rsp_rdata = sampled data for read/poll, 0 for write.
    - Then IDLE with lbus_a/lbus_do returned to 0.
  - GAP (poll only):
    - If (sample & mask)==0: go to RESP with rsp_timeout=0.
    - Otherwise increment the poll counter.
    - If the counter reaches POLL_MAX: go to RESP with rsp_timeout=1 and rsp_rdata = last sample.
    - Otherwise go to SETUP for another read.
- Poll mask=0 terminates after the first read (condition true).
- lbus_wr and lbus_rd are never both 1. Strobes never toggle while the address changes.
- Latency:
  - Write/read: cmd accept to rsp_valid = SETUP_CYC + STB_CYC + HOLD_CYC + 1 cycles.
  - Poll: the single-read latency above for each read, plus 1 GAP cycle per read.
- rsp_timeout is 0 whenever rsp_valid=0.
- Poll counter is 24 bits and saturates; no wrap-around.
- cmd_valid held high across consecutive commands gives back-to-back transfers separated by exactly one IDLE cycle.

Test Plan:
- Write: after reset, op=0 addr=16'h0002 wdata=16'h0001 (defaults) -> lbus_a=0002 for 6 cycles; lbus_wr high cycles 3-5 after accept; rsp_valid at cycle 7 with rdata=0.
- Read: op=1 addr=16'h0180, target drives lbus_di=16'hA5C3 -> lbus_rd high 3 cycles; rsp_rdata=A5C3; lbus_wr never asserted.
- Poll success: op=2 mask=16'h0001, lbus_di=0001 for 3 reads then 0000 -> 4 read strobes; rsp_timeout=0; rdata=0000.
- Poll timeout: POLL_MAX=5, lbus_di stuck at 0001 -> exactly 5 read strobes; rsp_valid with rsp_timeout=1, rdata=0001.
- Reset mid-STROBE during a write -> lbus_wr drops to 0 asynchronously; no rsp_valid; cmd_ready=1 after release.
- Back-to-back write then read with cmd_valid held high -> cmd_ready low during transfer; one IDLE cycle between strobes; HOLD_CYC=0 configuration also passes.
